// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, status bit positions and default MMIO map.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int unsigned STAT_RX_VALID  = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVERRUN   = 2;
  localparam int unsigned STAT_FRAME_ERR = 3;

  localparam logic [15:0] UART_TX_DATA_ADDR   = 16'hF000;
  localparam logic [15:0] UART_TX_STATUS_ADDR = 16'hF001;
  localparam logic [15:0] UART_RX_DATA_ADDR   = 16'hF010;
  localparam logic [15:0] UART_RX_STATUS_ADDR = 16'hF011;

endpackage

// File: rtl/uart_receiver_if.sv
// Core data-bus view of an MMIO peripheral: level request in, one-cycle done and read data out.
interface uart_receiver_if;
  logic [15:0] mmio_addr;
  logic        mmio_write;
  logic        mmio_req;
  logic [7:0]  mmio_rdata;
  logic        mmio_done;

  modport master (output mmio_addr, mmio_write, mmio_req, input mmio_rdata, mmio_done);
  modport slave  (input mmio_addr, mmio_write, mmio_req, output mmio_rdata, mmio_done);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word fall-through FIFO; pointers wrap naturally since DEPTH is a power of two.
module uart_rx_fifo #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a simultaneous push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver feeding a small FIFO, read by the core through a data and a status byte address.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_HZ    = 27_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DATA_ADDR   = UART_RX_DATA_ADDR,
  parameter logic [15:0] STATUS_ADDR = UART_RX_STATUS_ADDR
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           rx,
  uart_receiver_if.slave mmio
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_HZ / BAUD;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF - 1);
  localparam int unsigned AW           = $clog2(FIFO_DEPTH);

  logic        sync1_q, sync2_q, rx_last_q, rx_s, fall;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        stop_tick, push, ovr_set, fe_set;
  logic        overrun_q, overrun_d, frame_q, frame_d;
  logic        served_q, served_d, done_q, done_d;
  logic [7:0]  rdata_q, rdata_d, fifo_head, status;
  logic        fifo_full, fifo_empty, hit, accept, rd_data, rd_status, pop;
  logic [AW:0] fifo_count;

  assign rx_s = sync2_q;
  assign fall = rx_last_q && !sync2_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_last_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_last_q <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: if (cnt_q == HALF_LAST) begin
        cnt_d   = '0;
        state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == BIT_LAST) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == BIT_LAST) begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    stop_tick = (state_q == RX_STOP) && (cnt_q == BIT_LAST);
    push      = stop_tick && rx_s;
    ovr_set   = stop_tick && rx_s && fifo_full && !pop;
    fe_set    = stop_tick && !rx_s;
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(shift_q),
    .rdata_o(fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign status = {4'b0000, frame_q, overrun_q, fifo_full, fifo_count != '0};

  // served blocks re-acceptance while the core keeps req high through done.
  always_comb begin
    hit       = (mmio.mmio_addr == DATA_ADDR) || (mmio.mmio_addr == STATUS_ADDR);
    accept    = mmio.mmio_req && hit && !served_q;
    rd_data   = accept && !mmio.mmio_write && (mmio.mmio_addr == DATA_ADDR);
    rd_status = accept && !mmio.mmio_write && (mmio.mmio_addr == STATUS_ADDR);
    pop       = rd_data && !fifo_empty;
    done_d    = accept;
    rdata_d   = '0;
    if (rd_data && !fifo_empty) rdata_d = fifo_head;
    if (rd_status)              rdata_d = status;
    served_d  = !mmio.mmio_req ? 1'b0 : (accept ? 1'b1 : served_q);
    overrun_d = ovr_set ? 1'b1 : (rd_status ? 1'b0 : overrun_q);
    frame_d   = fe_set  ? 1'b1 : (rd_status ? 1'b0 : frame_q);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      served_q  <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      served_q  <= served_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      overrun_q <= overrun_d;
      frame_q   <= frame_d;
    end
  end

  assign mmio.mmio_done  = done_q;
  assign mmio.mmio_rdata = rdata_q;

endmodule
